regfile_sync: RTL and testbench
===============================

Name: regfile_sync

Overview:
Clocked, parametrised successor to the latch-based register file. Holds NUM_REGS architectural registers: index 0 is hard-wired zero, index SP_IDX is the stack pointer, and all others are general purpose. Provides four combinational read ports (two operand ports, one store-source port, one observation port), one edge-triggered write port, and hardware push/pop adjustment of SP. Sits between decode and execute in the core datapath.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, width of every register index
NUM_REGS, 18, number of indices implemented (0..NUM_REGS-1); must satisfy NUM_REGS <= 2**ADDR_W
SP_IDX, 17, index of the stack pointer; must be < NUM_REGS and != 0
SP_RESET, 32'h0000_FFFC, SP value after reset
SP_STEP, 4, amount subtracted on push and added on pop
INVALID_VAL, 32'hDEAD_BEEF, value returned for reads of unimplemented indices

Ports:
clk_in  input  1  clock; all state updates on its rising edge
rst_in  input  1  reset, asynchronous, active-high
reg1_in  input  ADDR_W  read index, port 1
reg2_in  input  ADDR_W  read index, port 2
reg_source_in  input  ADDR_W  read index, store-source port
reg_obs_sel_in  input  ADDR_W  read index, observation/debug port
reg_dest_in  input  ADDR_W  write index
data_in  input  DATA_W  write data
reg_wen_in  input  1  write enable
sp_push_in  input  1  decrement SP by SP_STEP
sp_pop_in  input  1  increment SP by SP_STEP
data1_out  output  DATA_W  read data, port 1
data2_out  output  DATA_W  read data, port 2
source_data_out  output  DATA_W  read data, store-source port
reg_obs_data_out  output  DATA_W  read data, observation port
sp_out  output  DATA_W  current SP, always visible
write_err_out  output  1  sticky flag: a write targeted an unimplemented index

Behaviour:
- Reset (rst_in high, asynchronous): GPRs 1..NUM_REGS-1 except SP_IDX clear to 0; SP loads SP_RESET; write_err_out clears to 0. Read outputs reflect reset state combinationally. Reset dominates every other input, including during an active push, pop or write.
- Reads are combinational with zero latency.
  - Index 0 returns 0.
  - Index in 1..NUM_REGS-1 returns the register contents.
  - Index >= NUM_REGS returns INVALID_VAL.
- Write: on a rising edge with reg_wen_in=1:
  - dest 0: ignored, no error.
  - dest in 1..NUM_REGS-1: register loads data_in.
  - dest >= NUM_REGS: no register changes; write_err_out is set and stays high until reset.
- SP update priority on each edge:
  - An explicit write to SP_IDX wins over push/pop.
  - Otherwise, push alone gives SP - SP_STEP; pop alone gives SP + SP_STEP.
  - Push and pop together leave SP unchanged.
  - All SP arithmetic is modulo 2**DATA_W; 0 - SP_STEP wraps with no flag.
- Push/pop with reg_wen_in=0 is legal. Push/pop with a write to a non-SP register performs both updates in the same cycle.
- No read-during-write hazard without the optional feature: reads return the pre-edge value until the edge commits.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: each read port whose index equals reg_dest_in, while reg_wen_in=1 and the index is in 1..NUM_REGS-1, returns data_in combinationally (write-through forwarding). SP push/pop is not forwarded: ports read pre-edge SP, but an explicit SP write is forwarded. Index 0 and out-of-range indices are never forwarded.
- Undefined: no forwarding; behaviour is exactly as described under Behaviour.

Decomposition:
- Package regfile_pkg holds:
  - ZERO_IDX
  - default SP_IDX, SP_RESET, SP_STEP, INVALID_VAL
  - a reg_idx_t typedef (ADDR_W bits)
  - a reg_data_t typedef (DATA_W bits)
- Sub-module regfile_read_port: one index in, register array in, plus write-forward inputs; applies the zero/invalid/bypass rules. Instantiated four times.
- The write decode and SP next-state logic stay in the top module.

Test Plan:
- Reset with defaults -> every read port at indices 1..16 returns 0; index 17 returns 32'h0000_FFFC; write_err_out=0.
- Write 32'h1234_5678 to index 5 -> reg1_in=5 reads old value 0 before the edge and 32'h1234_5678 after; writing index 0 leaves reads of index 0 at 0.
- Three pushes, then one pop -> sp_out goes 0xFFFC, 0xFFF8, 0xFFF4, 0xFFF0, 0xFFF4. Push+pop together -> unchanged. Push with SP at 0 -> 32'hFFFF_FFFC.
- Push combined with an explicit write of 32'h0000_8000 to SP_IDX -> SP = 32'h0000_8000.
- Write to index 20 -> no register changes, write_err_out rises and stays 1. Reads of index 20 return 32'hDEAD_BEEF. Asserting rst_in mid-cycle clears the flag immediately.
- With REGFILE_BYPASS_EN: reg_wen_in=1, reg_dest_in=3, data_in=32'hCAFE_0003, reg2_in=3 -> data2_out=32'hCAFE_0003 in the same cycle. Without the macro -> data2_out holds the old value until after the edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the clocked register file.
//   ZERO_IDX         hard-wired zero register index
//   DEFAULT_*        default geometry / SP / invalid-read values
//   reg_idx_t        register index (default ADDR_W bits)
//   reg_data_t       register word (default DATA_W bits)
//   sp_op_e          decoded stack-pointer adjustment
package regfile_pkg;

  localparam int unsigned DEFAULT_ADDR_W   = 5;
  localparam int unsigned DEFAULT_DATA_W   = 32;
  localparam int unsigned DEFAULT_NUM_REGS = 18;

  localparam int unsigned ZERO_IDX         = 0;
  localparam int unsigned DEFAULT_SP_IDX   = 17;
  localparam logic [31:0] DEFAULT_SP_RESET = 32'h0000_FFFC;
  localparam int unsigned DEFAULT_SP_STEP  = 4;
  localparam logic [31:0] DEFAULT_INVALID  = 32'hDEAD_BEEF;

  typedef logic [DEFAULT_ADDR_W-1:0] reg_idx_t;
  typedef logic [DEFAULT_DATA_W-1:0] reg_data_t;

  typedef enum logic [1:0] {
    SP_HOLD,
    SP_PUSH,
    SP_POP
  } sp_op_e;

  // Push and pop together cancel out.
  function automatic sp_op_e decode_sp_op(input logic push, input logic pop);
    if (push && !pop)      return SP_PUSH;
    else if (pop && !push) return SP_POP;
    else                   return SP_HOLD;
  endfunction

endpackage

// File: rtl/regfile_sync_if.sv
// regfile_sync_if: bus between decode/execute and the register file.
//   master: drives read/write indices, write data/enable, push/pop;
//           receives the four read ports, sp_out and write_err_out.
//   slave : the register file side.
interface regfile_sync_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic [ADDR_W-1:0] reg1_in;
  logic [ADDR_W-1:0] reg2_in;
  logic [ADDR_W-1:0] reg_source_in;
  logic [ADDR_W-1:0] reg_obs_sel_in;
  logic [ADDR_W-1:0] reg_dest_in;
  logic [DATA_W-1:0] data_in;
  logic              reg_wen_in;
  logic              sp_push_in;
  logic              sp_pop_in;
  logic [DATA_W-1:0] data1_out;
  logic [DATA_W-1:0] data2_out;
  logic [DATA_W-1:0] source_data_out;
  logic [DATA_W-1:0] reg_obs_data_out;
  logic [DATA_W-1:0] sp_out;
  logic              write_err_out;

  modport master (
    output reg1_in, reg2_in, reg_source_in, reg_obs_sel_in,
    output reg_dest_in, data_in, reg_wen_in, sp_push_in, sp_pop_in,
    input  data1_out, data2_out, source_data_out, reg_obs_data_out,
    input  sp_out, write_err_out
  );

  modport slave (
    input  reg1_in, reg2_in, reg_source_in, reg_obs_sel_in,
    input  reg_dest_in, data_in, reg_wen_in, sp_push_in, sp_pop_in,
    output data1_out, data2_out, source_data_out, reg_obs_data_out,
    output sp_out, write_err_out
  );
endinterface

// File: rtl/regfile_read_port.sv
// regfile_read_port: one combinational read port.
//   idx_in      read index
//   regs_in     current register array
//   fwd_en_in   a forwardable write is in flight this cycle
//   fwd_idx_in  destination index of that write
//   fwd_data_in data of that write
//   data_out    0 for index 0, INVALID_VAL beyond NUM_REGS-1, otherwise
//               forwarded data or register contents
module regfile_read_port #(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       ADDR_W      = 5,
  parameter int unsigned       NUM_REGS    = 18,
  parameter logic [DATA_W-1:0] INVALID_VAL = 32'hDEAD_BEEF
) (
  input  logic [ADDR_W-1:0] idx_in,
  input  logic [DATA_W-1:0] regs_in [NUM_REGS],
  input  logic              fwd_en_in,
  input  logic [ADDR_W-1:0] fwd_idx_in,
  input  logic [DATA_W-1:0] fwd_data_in,
  output logic [DATA_W-1:0] data_out
);
  import regfile_pkg::*;

  always_comb begin
    data_out = '0;
    if (32'(idx_in) == ZERO_IDX) begin
      data_out = '0;
    end else if (32'(idx_in) >= NUM_REGS) begin
      data_out = INVALID_VAL;
    end else if (fwd_en_in && (fwd_idx_in == idx_in)) begin
      data_out = fwd_data_in;
    end else begin
      data_out = regs_in[idx_in];
    end
  end
endmodule

// File: rtl/regfile_sync.sv
// regfile_sync: clocked register file with hard-wired zero, stack pointer
// and sticky out-of-range write error.
//   clk_in  clock, rising edge
//   rst_in  asynchronous active-high reset
//   bus     regfile_sync_if.slave: four read ports, one write port,
//           push/pop, sp_out, write_err_out
// Optional macro REGFILE_BYPASS_EN: forward an in-flight write to matching
// read ports (push/pop is never forwarded).
module regfile_sync
  import regfile_pkg::*;
#(
  parameter int unsigned       DATA_W      = DEFAULT_DATA_W,
  parameter int unsigned       ADDR_W      = DEFAULT_ADDR_W,
  parameter int unsigned       NUM_REGS    = DEFAULT_NUM_REGS,
  parameter int unsigned       SP_IDX      = DEFAULT_SP_IDX,
  parameter logic [DATA_W-1:0] SP_RESET    = DEFAULT_SP_RESET,
  parameter int unsigned       SP_STEP     = DEFAULT_SP_STEP,
  parameter logic [DATA_W-1:0] INVALID_VAL = DEFAULT_INVALID
) (
  input  logic             clk_in,
  input  logic             rst_in,
  regfile_sync_if.slave    bus
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              write_err_q;
  logic              write_err_d;

  logic   wr_zero;
  logic   wr_oob;
  logic   wr_valid;
  sp_op_e sp_op;
  logic   fwd_en;

  always_comb begin
    wr_zero  = (32'(bus.reg_dest_in) == ZERO_IDX);
    wr_oob   = (32'(bus.reg_dest_in) >= NUM_REGS);
    wr_valid = bus.reg_wen_in && !wr_zero && !wr_oob;
    sp_op    = decode_sp_op(bus.sp_push_in, bus.sp_pop_in);
  end

`ifdef REGFILE_BYPASS_EN
  assign fwd_en = wr_valid;
`else
  assign fwd_en = 1'b0;
`endif

  // Push/pop is applied first; an explicit write to SP then overrides it,
  // while a write elsewhere leaves the push/pop result in place.
  always_comb begin
    regs_d      = regs_q;
    write_err_d = write_err_q;
    unique case (sp_op)
      SP_PUSH: regs_d[SP_IDX] = regs_q[SP_IDX] - DATA_W'(SP_STEP);
      SP_POP:  regs_d[SP_IDX] = regs_q[SP_IDX] + DATA_W'(SP_STEP);
      default: regs_d[SP_IDX] = regs_q[SP_IDX];
    endcase
    if (wr_valid) begin
      regs_d[bus.reg_dest_in] = bus.data_in;
    end
    if (bus.reg_wen_in && wr_oob) begin
      write_err_d = 1'b1;
    end
    regs_d[ZERO_IDX] = '0;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == SP_IDX) ? SP_RESET : '0;
      end
      write_err_q <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      write_err_q <= write_err_d;
    end
  end

  regfile_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .INVALID_VAL(INVALID_VAL)
  ) u_rd1 (
    .idx_in(bus.reg1_in), .regs_in(regs_q), .fwd_en_in(fwd_en),
    .fwd_idx_in(bus.reg_dest_in), .fwd_data_in(bus.data_in), .data_out(bus.data1_out)
  );

  regfile_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .INVALID_VAL(INVALID_VAL)
  ) u_rd2 (
    .idx_in(bus.reg2_in), .regs_in(regs_q), .fwd_en_in(fwd_en),
    .fwd_idx_in(bus.reg_dest_in), .fwd_data_in(bus.data_in), .data_out(bus.data2_out)
  );

  regfile_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .INVALID_VAL(INVALID_VAL)
  ) u_rd_src (
    .idx_in(bus.reg_source_in), .regs_in(regs_q), .fwd_en_in(fwd_en),
    .fwd_idx_in(bus.reg_dest_in), .fwd_data_in(bus.data_in), .data_out(bus.source_data_out)
  );

  regfile_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .INVALID_VAL(INVALID_VAL)
  ) u_rd_obs (
    .idx_in(bus.reg_obs_sel_in), .regs_in(regs_q), .fwd_en_in(fwd_en),
    .fwd_idx_in(bus.reg_dest_in), .fwd_data_in(bus.data_in), .data_out(bus.reg_obs_data_out)
  );

  assign bus.sp_out        = regs_q[SP_IDX];
  assign bus.write_err_out = write_err_q;

endmodule

// File: tb/tb_regfile_sync.sv
// tb_regfile_sync: self-checking bench for regfile_sync with default
// parameters. Expected values are queued when stimulus is driven and
// popped when the DUT output is sampled.
module tb_regfile_sync;
  import regfile_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  reg_data_t exp_q[$];
  reg_data_t exp;

  regfile_sync_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_sync dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic drive_idle();
    bus.reg1_in        = '0;
    bus.reg2_in        = '0;
    bus.reg_source_in  = '0;
    bus.reg_obs_sel_in = '0;
    bus.reg_dest_in    = '0;
    bus.data_in        = '0;
    bus.reg_wen_in     = 1'b0;
    bus.sp_push_in     = 1'b0;
    bus.sp_pop_in      = 1'b0;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.reg1_in        = 5'(i);
      bus.reg2_in        = 5'(i);
      bus.reg_source_in  = 5'(i);
      bus.reg_obs_sel_in = 5'(i);
      for (int k = 0; k < 4; k++)
        exp_q.push_back((i == 17) ? 32'h0000_FFFC : (i >= 18) ? 32'hDEAD_BEEF : 32'h0);
      #1;
      exp = exp_q.pop_front(); checks++;
      if (bus.data1_out !== exp) begin failures++;
        $display("FAIL reset_rd1[%0d] actual=%h required=%h", i, bus.data1_out, exp); end
      exp = exp_q.pop_front(); checks++;
      if (bus.data2_out !== exp) begin failures++;
        $display("FAIL reset_rd2[%0d] actual=%h required=%h", i, bus.data2_out, exp); end
      exp = exp_q.pop_front(); checks++;
      if (bus.source_data_out !== exp) begin failures++;
        $display("FAIL reset_src[%0d] actual=%h required=%h", i, bus.source_data_out, exp); end
      exp = exp_q.pop_front(); checks++;
      if (bus.reg_obs_data_out !== exp) begin failures++;
        $display("FAIL reset_obs[%0d] actual=%h required=%h", i, bus.reg_obs_data_out, exp); end
    end
    checks++;
    if (bus.sp_out !== 32'h0000_FFFC) begin failures++;
      $display("FAIL reset_sp actual=%h required=%h", bus.sp_out, 32'h0000_FFFC); end
    checks++;
    if (bus.write_err_out !== 1'b0) begin failures++;
      $display("FAIL reset_err actual=%b required=0", bus.write_err_out); end
    drive_idle();
  endtask

  task automatic test_write();
    @(negedge clk);
    bus.reg1_in     = 5'd5;
    bus.reg_dest_in = 5'd5;
    bus.data_in     = 32'h1234_5678;
    bus.reg_wen_in  = 1'b1;
`ifdef REGFILE_BYPASS_EN
    exp_q.push_back(32'h1234_5678);
`else
    exp_q.push_back(32'h0);
`endif
    exp_q.push_back(32'h1234_5678);
    #1;
    exp = exp_q.pop_front(); checks++;
    if (bus.data1_out !== exp) begin failures++;
      $display("FAIL write_pre actual=%h required=%h", bus.data1_out, exp); end
    tick();
    bus.reg_wen_in = 1'b0;
    #1;
    exp = exp_q.pop_front(); checks++;
    if (bus.data1_out !== exp) begin failures++;
      $display("FAIL write_post actual=%h required=%h", bus.data1_out, exp); end
    // write to index 0 is discarded
    bus.reg_dest_in = 5'd0;
    bus.data_in     = 32'hFFFF_FFFF;
    bus.reg_wen_in  = 1'b1;
    bus.reg2_in     = 5'd0;
    exp_q.push_back(32'h0);
    tick();
    bus.reg_wen_in = 1'b0;
    #1;
    exp = exp_q.pop_front(); checks++;
    if (bus.data2_out !== exp) begin failures++;
      $display("FAIL write_zero actual=%h required=%h", bus.data2_out, exp); end
    checks++;
    if (bus.write_err_out !== 1'b0) begin failures++;
      $display("FAIL write_zero_err actual=%b required=0", bus.write_err_out); end
    drive_idle();
  endtask

  task automatic test_sp();
    reg_data_t seq [5] = '{32'h0000_FFF8, 32'h0000_FFF4, 32'h0000_FFF0, 32'h0000_FFF4, 32'h0000_FFF4};
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      bus.sp_push_in = (i < 3) || (i == 4);
      bus.sp_pop_in  = (i >= 3);
      exp_q.push_back(seq[i]);
      tick();
      exp = exp_q.pop_front(); checks++;
      if (bus.sp_out !== exp) begin failures++;
        $display("FAIL sp_step[%0d] actual=%h required=%h", i, bus.sp_out, exp); end
    end
    drive_idle();
    // load SP with 0 then push: wraps
    bus.reg_dest_in = 5'd17;
    bus.data_in     = 32'h0;
    bus.reg_wen_in  = 1'b1;
    tick();
    drive_idle();
    bus.sp_push_in = 1'b1;
    exp_q.push_back(32'hFFFF_FFFC);
    tick();
    bus.sp_push_in = 1'b0;
    exp = exp_q.pop_front(); checks++;
    if (bus.sp_out !== exp) begin failures++;
      $display("FAIL sp_wrap actual=%h required=%h", bus.sp_out, exp); end
    drive_idle();
  endtask

  task automatic test_sp_write();
    bus.sp_push_in  = 1'b1;
    bus.reg_dest_in = 5'd17;
    bus.data_in     = 32'h0000_8000;
    bus.reg_wen_in  = 1'b1;
    exp_q.push_back(32'h0000_8000);
    tick();
    exp = exp_q.pop_front(); checks++;
    if (bus.sp_out !== exp) begin failures++;
      $display("FAIL sp_write_wins actual=%h required=%h", bus.sp_out, exp); end
    // push alongside a write to another register: both take effect
    bus.reg_dest_in = 5'd6;
    bus.data_in     = 32'h0000_0066;
    bus.reg_obs_sel_in = 5'd6;
    exp_q.push_back(32'h0000_7FFC);
    exp_q.push_back(32'h0000_0066);
    tick();
    drive_idle();
    bus.reg_obs_sel_in = 5'd6;
    #1;
    exp = exp_q.pop_front(); checks++;
    if (bus.sp_out !== exp) begin failures++;
      $display("FAIL sp_push_with_write actual=%h required=%h", bus.sp_out, exp); end
    exp = exp_q.pop_front(); checks++;
    if (bus.reg_obs_data_out !== exp) begin failures++;
      $display("FAIL gpr_with_push actual=%h required=%h", bus.reg_obs_data_out, exp); end
    drive_idle();
  endtask

  task automatic test_invalid();
    bus.reg_dest_in = 5'd20;
    bus.data_in     = 32'h0000_1234;
    bus.reg_wen_in  = 1'b1;
    tick();
    drive_idle();
    bus.reg1_in        = 5'd20;
    bus.reg2_in        = 5'd5;
    bus.reg_obs_sel_in = 5'd6;
    bus.reg_source_in  = 5'd31;
    exp_q.push_back(32'hDEAD_BEEF);
    exp_q.push_back(32'h1234_5678);
    exp_q.push_back(32'h0000_0066);
    exp_q.push_back(32'hDEAD_BEEF);
    #1;
    checks++;
    if (bus.write_err_out !== 1'b1) begin failures++;
      $display("FAIL oob_err_set actual=%b required=1", bus.write_err_out); end
    exp = exp_q.pop_front(); checks++;
    if (bus.data1_out !== exp) begin failures++;
      $display("FAIL oob_read20 actual=%h required=%h", bus.data1_out, exp); end
    exp = exp_q.pop_front(); checks++;
    if (bus.data2_out !== exp) begin failures++;
      $display("FAIL oob_r5_kept actual=%h required=%h", bus.data2_out, exp); end
    exp = exp_q.pop_front(); checks++;
    if (bus.reg_obs_data_out !== exp) begin failures++;
      $display("FAIL oob_r6_kept actual=%h required=%h", bus.reg_obs_data_out, exp); end
    exp = exp_q.pop_front(); checks++;
    if (bus.source_data_out !== exp) begin failures++;
      $display("FAIL oob_read31 actual=%h required=%h", bus.source_data_out, exp); end
    tick();
    tick();
    checks++;
    if (bus.write_err_out !== 1'b1) begin failures++;
      $display("FAIL oob_err_sticky actual=%b required=1", bus.write_err_out); end
    drive_idle();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.reg1_in    = 5'd5;
    bus.sp_push_in = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.write_err_out !== 1'b0) begin failures++;
      $display("FAIL rst_mid_err actual=%b required=0", bus.write_err_out); end
    checks++;
    if (bus.data1_out !== 32'h0) begin failures++;
      $display("FAIL rst_mid_r5 actual=%h required=%h", bus.data1_out, 32'h0); end
    // push held across an edge while in reset has no effect
    tick();
    checks++;
    if (bus.sp_out !== 32'h0000_FFFC) begin failures++;
      $display("FAIL rst_dominates_push actual=%h required=%h", bus.sp_out, 32'h0000_FFFC); end
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_bypass();
    @(negedge clk);
    bus.reg_dest_in = 5'd3;
    bus.data_in     = 32'hCAFE_0003;
    bus.reg_wen_in  = 1'b1;
    bus.reg2_in     = 5'd3;
    bus.reg1_in     = 5'd17;
    bus.sp_push_in  = 1'b1;
`ifdef REGFILE_BYPASS_EN
    exp_q.push_back(32'hCAFE_0003);
`else
    exp_q.push_back(32'h0);
`endif
    exp_q.push_back(32'h0000_FFFC);
    exp_q.push_back(32'hCAFE_0003);
    exp_q.push_back(32'h0000_FFF8);
    #1;
    exp = exp_q.pop_front(); checks++;
    if (bus.data2_out !== exp) begin failures++;
      $display("FAIL bypass_same_cycle actual=%h required=%h", bus.data2_out, exp); end
    exp = exp_q.pop_front(); checks++;
    if (bus.data1_out !== exp) begin failures++;
      $display("FAIL push_not_forwarded actual=%h required=%h", bus.data1_out, exp); end
    tick();
    bus.reg_wen_in = 1'b0;
    bus.sp_push_in = 1'b0;
    #1;
    exp = exp_q.pop_front(); checks++;
    if (bus.data2_out !== exp) begin failures++;
      $display("FAIL bypass_after_edge actual=%h required=%h", bus.data2_out, exp); end
    exp = exp_q.pop_front(); checks++;
    if (bus.data1_out !== exp) begin failures++;
      $display("FAIL push_after_edge actual=%h required=%h", bus.data1_out, exp); end
    drive_idle();
  endtask

  task automatic test_back_to_back();
    reg_data_t v;
    @(negedge clk);
    for (int i = 1; i < 17; i++) begin
      v = 32'h0101_0101 * i ^ 32'hA5A5_0000;
      bus.reg_dest_in = 5'(i);
      bus.data_in     = v;
      bus.reg_wen_in  = 1'b1;
      exp_q.push_back(v);
      tick();
    end
    drive_idle();
    for (int i = 1; i < 17; i++) begin
      bus.reg_source_in = 5'(i);
      #1;
      exp = exp_q.pop_front(); checks++;
      if (bus.source_data_out !== exp) begin failures++;
        $display("FAIL b2b_r%0d actual=%h required=%h", i, bus.source_data_out, exp); end
    end
    checks++;
    if (bus.sp_out !== 32'h0000_FFF8) begin failures++;
      $display("FAIL b2b_sp_kept actual=%h required=%h", bus.sp_out, 32'h0000_FFF8); end
    drive_idle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_write();
    test_sp();
    test_sp_write();
    test_invalid();
    test_reset_mid();
    test_bypass();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
